// File: rtl/mul_share_pkg.sv
// Shared types and constants for the two-port multiplier scheduler.
// Optional zero-operand bypass: MUL_SHARE_ZERO_BYPASS_EN.
package mul_share_pkg;

    localparam int OPW        = 32;
    localparam int RESW       = 64;
    localparam int CNTW       = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/array32.sv
// Combinational 32x32 unsigned array multiplier; long ripple path,
// so callers must treat it as a multicycle path.
module array32
    import mul_share_pkg::*;
(
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic [RESW-1:0] c
);

    assign c = RESW'(a) * RESW'(b);

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler sharing one array32 between two requesters.
// Optional zero-operand bypass: MUL_SHARE_ZERO_BYPASS_EN.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int unsigned SETTLE = 2
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [RESW-1:0] resp_c,
    output logic            busy
);

    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_settle_chk
        $error("mul_share_ctrl: SETTLE out of range 1..15");
    end

    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE - 1);

    state_t          state;
    logic            rr;
    logic            owner;
    logic [CNTW-1:0] cnt;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [RESW-1:0] prod;
    logic            g0;
    logic            g1;
    logic            acc;
    logic [OPW-1:0]  a_sel;
    logic [OPW-1:0]  b_sel;

    // rr only matters when both ports are valid in the same cycle
    always_comb begin
        g0 = req0_valid && (!req1_valid || !rr);
        g1 = req1_valid && (!req0_valid || rr);
    end

    assign req0_ready = (state == IDLE) && g0;
    assign req1_ready = (state == IDLE) && g1;
    assign acc        = req0_ready || req1_ready;
    assign a_sel      = g1 ? req1_a : req0_a;
    assign b_sel      = g1 ? req1_b : req0_b;
    assign busy       = (state != IDLE);

    array32 u_array32 (
        .a (a_q),
        .b (b_q),
        .c (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            owner       <= 1'b0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resp_c      <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        owner <= g1;
                        rr    <= ~g1;
                        cnt   <= CNT_INIT;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                        if (a_sel == '0 || b_sel == '0) begin
                            resp_c      <= '0;
                            resp0_valid <= ~g1;
                            resp1_valid <= g1;
                            state       <= RESP;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        resp_c      <= prod;
                        resp0_valid <= ~owner;
                        resp1_valid <= owner;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    // only the owner's ready releases the result
                    if (owner ? resp1_ready : resp0_ready) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Two-port scheduler that shares a single combinational 32×32 `array32` multiplier between two requesters. The multiplier's ripple path is too long for one cycle, so the controller treats it as a multicycle path:

- latches the operands of one granted request;
- holds them stable for a fixed settle window;
- registers the 64-bit product;
- returns it to the requester that issued it.

It sits between the ALU issue logic (requester 0) and the bitwise/test-method unit (requester 1), in front of the shared `array32` instance.

## Interface
- `SETTLE`, default 2: number of CALC cycles the operands are held before the product is captured; legal range 1–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0's pair is accepted this cycle.
- `req0_a`, `req0_b` in 32 each: requester 0 unsigned operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as the requester 0 signals, for requester 1.
- `resp0_valid` out 1: result is for requester 0.
- `resp0_ready` in 1: requester 0 takes the result.
- `resp1_valid` out 1, `resp1_ready` in 1: same as the requester 0 response pair, for requester 1.
- `resp_c` out 64: shared result bus; meaningful only while one of the `respN_valid` signals is high.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, CALC, RESP.
- **IDLE**
  - Grant is combinational: if one `reqN_valid` is high, that port wins.
  - If both are high, the port named by the round-robin pointer `rr` wins.
  - `reqN_ready` is high only for the granted port, and only in IDLE.
- **Accept** (`valid && ready`):
  - latch a, b and the owner id;
  - set `rr` to the other port;
  - load the settle counter with `SETTLE-1`;
  - go to CALC.
- **CALC**
  - The latched operands drive `array32` continuously.
  - The counter decrements each cycle.
  - At count 0, register the 64-bit product into `resp_c` and go to RESP.
- **RESP**
  - `respN_valid` is high for the owner only.
  - `resp_c` and valid hold until the owner's `respN_ready` is high.
  - Then go to IDLE.
  - The other port's `respN_ready` is ignored.
- **Arithmetic:** unsigned, full 64-bit product, no truncation or overflow flag.
- **Reset values:** state IDLE, `rr`=0, `req0_ready`/`req1_ready`/`resp0_valid`/`resp1_valid`/`busy` = 0, `resp_c` = 0, counter 0.
- **Reset mid-operation:** an in-flight request is abandoned and no response is issued. The requester must re-issue it.
- **Requester behaviour:** a requester whose valid drops before acceptance is simply not served. There is no error.

## Timing
- Accept in cycle T.
- CALC occupies T+1 … T+SETTLE.
- The product is captured on the edge ending T+SETTLE.
- `respN_valid` is high from T+SETTLE+1.
- **Minimum occupancy:** with the response taken immediately, IDLE is re-entered at T+SETTLE+2. The next accept can occur in that cycle.
- Peak throughput is therefore one multiply per SETTLE+2 cycles.
- **Ready timing:** `reqN_ready` depends combinationally on `reqN_valid`. No valid depends on a ready.
- **Back-to-back contention:** when both requesters stay valid, service alternates 0,1,0,1…

## Configuration
- Macro: `MUL_SHARE_ZERO_BYPASS_EN`.
- **Defined:** at accept, if either operand is 0, the controller skips CALC. It goes IDLE → RESP with `resp_c` = 0, and `respN_valid` is high at T+1.
- **Undefined:** every request takes the full CALC window, including zero operands.

## Structure
- Package `mul_share_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, CALC=2'd1, RESP=2'd2);
  - `OPW` = 32 and `RESW` = 64;
  - the `SETTLE` bounds.
- One sub-module: the existing `array32` (a[31:0], b[31:0] → c[63:0]), instantiated once.
- Arbitration, counter and the FSM stay inline.

## Test plan
- **Single request:** req0 a=0x0000000F, b=0xFFFFFFFF, SETTLE=2, resp0_ready held high.
  - `resp0_valid` is high at T+3 with `resp_c`=0x0000000EFFFFFFF1.
  - `busy` is low at T+4.
- **Simultaneous requests:** after reset, req0 (3×5) and req1 (7×9) assert together.
  - req0 is served first: `resp_c`=15.
  - Then req1: `resp_c`=63.
  - A third simultaneous pair is granted to req0 again (`rr` has returned to 0).
- **Response backpressure:** `resp1_ready` held low for 5 cycles with a=0xFFFFFFFF, b=0xFFFFFFFF.
  - `resp_c`=0xFFFFFFFE00000001 is stable throughout.
  - Requesters are not granted during this time.
  - The controller leaves RESP the cycle after ready rises.
- **Reset mid-operation:** `rst` pulses during CALC.
  - The next cycle shows all outputs 0 and state IDLE.
  - No `respN_valid` follows.
  - A new req0 (2×2) then returns 4.
- **Zero operand:** req0 with a=0, b=0x12345678.
  - With `MUL_SHARE_ZERO_BYPASS_EN`: `resp0_valid` is high at T+1 with `resp_c`=0.
  - Without it: `resp0_valid` is high at T+SETTLE+1 with `resp_c`=0.
- **Maximum settle:** SETTLE=15, a=0x80000000, b=2.
  - `resp_c`=0x0000000100000000 is valid exactly at T+16.
